// File: rtl/noc_inject_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_inject_pkg
// Description : Shared definitions for the NoC flit injector: packet framing
//               states and the default flit width.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_inject_pkg;

    localparam int unsigned C_DEFAULT_FLIT_SIZE = 32;

    // Hermes-style packet framing: one header flit, one size flit holding the
    // payload flit count, then that many payload flits.
    typedef enum logic [1:0] {
        ST_HEADER  = 2'd0,
        ST_SIZE    = 2'd1,
        ST_PAYLOAD = 2'd2
    } frame_state_e;

endpackage
`default_nettype wire

// File: rtl/noc_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : noc_sync_fifo
// Description : Show-ahead synchronous FIFO. The head entry is always visible
//               on o_head while o_empty is low.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               i_push     - write i_data (ignored while full, even on a pop)
//               i_pop      - drop the head entry (ignored while empty)
//               i_data     - write data
//               o_full     - BUFFER_DEPTH entries held
//               o_empty    - no entries held
//               o_head     - oldest entry
//               o_count    - occupancy, 0..BUFFER_DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module noc_sync_fifo #(
    parameter int unsigned FLIT_SIZE    = 32,
    parameter int unsigned BUFFER_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_push,
    input  logic                            i_pop,
    input  logic [FLIT_SIZE-1:0]            i_data,
    output logic                            o_full,
    output logic                            o_empty,
    output logic [FLIT_SIZE-1:0]            o_head,
    output logic [$clog2(BUFFER_DEPTH):0]   o_count
);

    localparam int unsigned C_ADDR_W  = $clog2(BUFFER_DEPTH);
    localparam int unsigned C_COUNT_W = C_ADDR_W + 1;

    logic [FLIT_SIZE-1:0] r_mem [BUFFER_DEPTH];
    logic [C_ADDR_W-1:0]  r_wr_ptr;
    logic [C_ADDR_W-1:0]  r_rd_ptr;
    logic [C_COUNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == C_COUNT_W'(BUFFER_DEPTH));
    assign w_empty   = (r_count == '0);
    // A pop in the same cycle does not free a slot for a push while full.
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;

    // Pointers wrap naturally because BUFFER_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + C_ADDR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + C_ADDR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + C_COUNT_W'(1);
                2'b01:   r_count <= r_count - C_COUNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/noc_flit_injector.sv
`default_nettype none
// ============================================================================
// Module      : noc_flit_injector
// Description : Credit-based flit injector. Buffers source flits in a FIFO,
//               presents them to the router with tx/credit handshaking, and
//               follows packet framing so that packet completion and
//               end-of-application are reported only on packet boundaries.
// Ports       : clk_i, rst_i  - clock, synchronous active-high reset
//               src_valid_i / src_ready_o / src_data_i - source flit handshake
//               src_eoa_i     - source has no more packets
//               tx_o / credit_i / data_o - router flit handshake
//               eoa_o         - end of application (sticky)
//               pkt_sent_o    - one-cycle pulse after a packet's last flit leaves
//               busy_o        - flits buffered or packet partially sent
// Revision    : 1.0 - initial release
// ============================================================================
module noc_flit_injector
    import noc_inject_pkg::*;
#(
    parameter int unsigned FLIT_SIZE    = C_DEFAULT_FLIT_SIZE,
    parameter int unsigned BUFFER_DEPTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 src_valid_i,
    output logic                 src_ready_o,
    input  logic [FLIT_SIZE-1:0] src_data_i,
    input  logic                 src_eoa_i,
    output logic                 tx_o,
    input  logic                 credit_i,
    output logic [FLIT_SIZE-1:0] data_o,
    output logic                 eoa_o,
    output logic                 pkt_sent_o,
    output logic                 busy_o
);

    logic                          w_full;
    logic                          w_empty;
    logic [FLIT_SIZE-1:0]          w_head;
    logic [$clog2(BUFFER_DEPTH):0] w_count;

    logic w_ready;
    logic w_push;
    logic w_pop;

    frame_state_e         r_state;
    frame_state_e         w_state_nxt;
    logic [FLIT_SIZE-1:0] r_remaining;
    logic [FLIT_SIZE-1:0] w_remaining_nxt;
    logic                 w_pkt_done;
    logic                 r_pkt_sent;
    logic                 r_eoa_latched;

    // Ready depends only on registered state, never on credit_i.
    assign w_ready = !w_full && !r_eoa_latched;
    assign w_push  = src_valid_i && w_ready;
    assign w_pop   = !w_empty && credit_i;

    noc_sync_fifo #(
        .FLIT_SIZE    (FLIT_SIZE),
        .BUFFER_DEPTH (BUFFER_DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (src_data_i),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= ST_HEADER;
            r_remaining   <= '0;
            r_pkt_sent    <= 1'b0;
            r_eoa_latched <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_pkt_sent  <= w_pkt_done;
            // The latch only blocks later flits; one accepted in the same
            // cycle is already committed by w_push above.
            if (src_eoa_i) begin
                r_eoa_latched <= 1'b1;
            end
        end
    end

    // Framing advances only when a flit actually leaves toward the router.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_pkt_done      = 1'b0;
        if (w_pop) begin
            case (r_state)
                ST_HEADER: begin
                    w_state_nxt = ST_SIZE;
                end
                ST_SIZE: begin
                    w_remaining_nxt = w_head;
                    if (w_head == '0) begin
                        w_pkt_done  = 1'b1;
                        w_state_nxt = ST_HEADER;
                    end else begin
                        w_state_nxt = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    w_remaining_nxt = r_remaining - FLIT_SIZE'(1);
                    if (r_remaining == FLIT_SIZE'(1)) begin
                        w_pkt_done  = 1'b1;
                        w_state_nxt = ST_HEADER;
                    end
                end
                default: begin
                    w_state_nxt = ST_HEADER;
                end
            endcase
        end
    end

    assign src_ready_o = w_ready;
    assign tx_o        = !w_empty;
    assign data_o      = w_empty ? '0 : w_head;
    assign pkt_sent_o  = r_pkt_sent;
    assign busy_o      = (w_count != '0) || (r_state != ST_HEADER);
    // Once latched no further pushes can arrive, so this term is sticky by
    // construction: the FIFO stays empty and framing stays in HEADER.
    assign eoa_o       = r_eoa_latched && w_empty && (r_state == ST_HEADER);

endmodule
`default_nettype wire

// File: tb/tb_noc_flit_injector.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_flit_injector
// Description : Self-checking bench for noc_flit_injector. A packet-level
//               reference model (flit queue, flits-into-packet counter,
//               packet length from the size flit) predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_flit_injector;

    localparam int C_DEPTH = 8;

    logic        clk;
    logic        rst_i;
    logic        src_valid_i;
    logic        src_ready_o;
    logic [31:0] src_data_i;
    logic        src_eoa_i;
    logic        tx_o;
    logic        credit_i;
    logic [31:0] data_o;
    logic        eoa_o;
    logic        pkt_sent_o;
    logic        busy_o;

    noc_flit_injector #(
        .FLIT_SIZE    (32),
        .BUFFER_DEPTH (C_DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .src_valid_i (src_valid_i),
        .src_ready_o (src_ready_o),
        .src_data_i  (src_data_i),
        .src_eoa_i   (src_eoa_i),
        .tx_o        (tx_o),
        .credit_i    (credit_i),
        .data_o      (data_o),
        .eoa_o       (eoa_o),
        .pkt_sent_o  (pkt_sent_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_q[$];
    bit          m_latched = 1'b0;
    int          m_cnt     = 0;
    longint      m_total   = 0;
    bit          m_sent    = 1'b0;
    bit          last_push = 1'b0;

    logic [31:0] src_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [36:0] exp_vec();
        logic [31:0] d;
        d = (m_q.size() != 0) ? m_q[0] : 32'h0;
        return {m_q.size() != 0,
                (m_q.size() < C_DEPTH) && !m_latched,
                (m_q.size() != 0) || (m_cnt != 0),
                m_latched && (m_q.size() == 0) && (m_cnt == 0),
                m_sent, d};
    endfunction

    function automatic logic [36:0] obs_vec();
        return {tx_o, src_ready_o, busy_o, eoa_o, pkt_sent_o, data_o};
    endfunction

    // Drives one cycle and advances the model across the clock edge.
    task automatic step(input bit v, input logic [31:0] d, input bit e,
                        input bit c, input bit r);
        bit rdy, push, pop;
        logic [31:0] f;
        src_valid_i = v;
        src_data_i  = d;
        src_eoa_i   = e;
        credit_i    = c;
        rst_i       = r;
        rdy  = (m_q.size() < C_DEPTH) && !m_latched;
        push = v && rdy;
        pop  = (m_q.size() != 0) && c;
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_latched = 1'b0;
            m_cnt     = 0;
            m_total   = 0;
            m_sent    = 1'b0;
            last_push = 1'b0;
        end else begin
            m_sent = 1'b0;
            if (pop) begin
                f = m_q.pop_front();
                m_cnt++;
                if (m_cnt == 2) m_total = 2 + longint'(f);
                if (m_cnt >= 2 && m_cnt == m_total) begin
                    m_sent = 1'b1;
                    m_cnt  = 0;
                end
            end
            if (push) m_q.push_back(d);
            if (e) m_latched = 1'b1;
            last_push = push;
        end
        #1;
    endtask

    // Offers the next pending source flit; optionally flags eoa with the last.
    task automatic step_src(input bit en, input bit c, input bit eoa_last);
        bit v;
        logic [31:0] d;
        v = en && (src_q.size() != 0);
        d = v ? src_q[0] : 32'h0;
        step(v, d, eoa_last && v && (src_q.size() == 1), c, 1'b0);
        if (last_push) void'(src_q.pop_front());
    endtask

    task automatic test_reset();
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        rst_i = 1'b0;
        n_cmp++;
        if (obs_vec() !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL reset: got %h want %h", obs_vec(),
                     {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        end
    endtask

    task automatic test_stream();
        int pulses = 0;
        src_q = {32'h0000_0101, 32'h0000_0003, 32'hA, 32'hB, 32'hC};
        for (int i = 0; i < 10; i++) begin
            step_src(1'b1, 1'b1, 1'b0);
            if (pkt_sent_o) pulses++;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL stream cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (pulses != 1 || busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL stream_end: pulses %0d busy %b want 1 / 0", pulses, busy_o);
        end
    endtask

    task automatic test_backpressure();
        int pulses = 0;
        src_q = {32'h55, 32'h7, 32'h70, 32'h71, 32'h72, 32'h73, 32'h74, 32'h75, 32'h76};
        for (int i = 0; i < 10; i++) begin
            step_src(1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL bp_hold cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (src_ready_o !== 1'b0 || data_o !== 32'h55 || src_q.size() != 1) begin
            n_bad++;
            $display("FAIL bp_full: ready %b data %h left %0d want 0 / 00000055 / 1",
                     src_ready_o, data_o, src_q.size());
        end
        for (int i = 0; i < 14; i++) begin
            step_src(1'b1, 1'b1, 1'b0);
            if (pkt_sent_o) pulses++;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL bp_drain cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (pulses != 1 || busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_end: pulses %0d busy %b want 1 / 0", pulses, busy_o);
        end
    endtask

    task automatic test_zero_size();
        int pulses = 0;
        src_q = {32'h0202, 32'h0};
        for (int i = 0; i < 5; i++) begin
            step_src(1'b1, 1'b1, 1'b0);
            if (pkt_sent_o) pulses++;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL zero cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (pulses != 1 || busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_end: pulses %0d busy %b want 1 / 0", pulses, busy_o);
        end
    endtask

    task automatic test_eoa();
        src_q = {32'h33, 32'h2, 32'h11, 32'h22};
        for (int i = 0; i < 4; i++) begin
            step_src(1'b1, (i % 2) == 0, 1'b1);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL eoa_fill cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (src_ready_o !== 1'b0 || eoa_o !== 1'b0) begin
            n_bad++;
            $display("FAIL eoa_latch: ready %b eoa %b want 0 / 0", src_ready_o, eoa_o);
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 32'hDEAD, 1'b0, (i % 2) == 0, 1'b0);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL eoa_drain cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (eoa_o !== 1'b1 || busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL eoa_final: eoa %b busy %b want 1 / 0", eoa_o, busy_o);
        end
    endtask

    task automatic test_mid_reset();
        int pulses = 0;
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        src_q = {32'h44, 32'h6, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
        for (int i = 0; i < 6; i++) begin
            step_src(1'b1, i < 3, 1'b0);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL mrst_fill cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (m_q.size() != 4 || busy_o !== 1'b1) begin
            n_bad++;
            $display("FAIL mrst_setup: buffered %0d busy %b want 4 / 1", m_q.size(), busy_o);
        end
        step(1'b1, 32'hBAD, 1'b0, 1'b1, 1'b1);
        rst_i = 1'b0;
        n_cmp++;
        if (obs_vec() !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL mrst_after: got %h want %h", obs_vec(),
                     {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        end
        src_q = {32'h66, 32'h1, 32'h77};
        for (int i = 0; i < 6; i++) begin
            step_src(1'b1, 1'b1, 1'b0);
            if (pkt_sent_o) pulses++;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL mrst_pkt cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (pulses != 1) begin
            n_bad++;
            $display("FAIL mrst_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_random();
        int n;
        for (int i = 0; i < 400; i++) begin
            if (src_q.size() < 3) begin
                n = $urandom_range(0, 3);
                src_q.push_back($urandom);
                src_q.push_back(32'(n));
                for (int k = 0; k < n; k++) src_q.push_back($urandom);
            end
            step_src(($urandom % 4) != 0, ($urandom % 3) != 0, 1'b0);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 40; i++) begin
            step_src(1'b1, 1'b1, 1'b0);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL rnd_drain cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (busy_o !== 1'b0 || tx_o !== 1'b0) begin
            n_bad++;
            $display("FAIL rnd_idle: busy %b tx %b want 0 / 0", busy_o, tx_o);
        end
    endtask

    task automatic test_truncated();
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        src_q = {32'h99, 32'h5, 32'hE1, 32'hE2};
        for (int i = 0; i < 4; i++) begin
            step_src(1'b1, 1'b1, 1'b1);
        end
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
            n_cmp++;
            if (eoa_o !== 1'b0 || busy_o !== 1'b1 || obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL trunc cyc%0d: got %h want %h (eoa 0, busy 1)",
                         i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        src_valid_i = 1'b0;
        src_data_i  = 32'h0;
        src_eoa_i   = 1'b0;
        credit_i    = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_zero_size();
        test_eoa();
        test_mid_reset();
        test_random();
        test_truncated();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
